// File: rtl/dmem_pipelined_if.sv
// ============================================================================
// Module      : dmem_pipelined_if
// Description : Request/response bus between the LSU (master) and dmem (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_pipelined_if #(
  parameter int WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [WIDTH-1:0]   req_addr;
  logic [WIDTH-1:0]   req_wdata;
  logic [WIDTH/8-1:0] req_byteen;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_rdata;
  logic               rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_byteen, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_byteen, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_pipelined.sv
// ============================================================================
// Module      : dmem_pipelined
// Description : Word-array data memory with valid/ready requests, access
//               checking and a READ_LATENCY-deep in-order response pipeline.
//               Optional access counters: define DMEM_ACCESS_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_pipelined #(
  parameter int WIDTH        = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  dmem_pipelined_if.slave   bus
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [31:0]       cnt_load,
  output logic [31:0]       cnt_store,
  output logic [31:0]       cnt_err
`endif
);

  localparam int NB    = WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int AU_W  = IDX_W + OFF_W;

  logic [WIDTH-1:0]        r_mem [DEPTH_WORDS];
  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_err;
  logic [WIDTH-1:0]        r_data [READ_LATENCY];

  logic             w_stall;
  logic             w_accept;
  logic             w_range_err;
  logic             w_be_err;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_off;
  logic [WIDTH-1:0] w_rd_word;

  assign w_stall       = bus.rsp_valid && !bus.rsp_ready;
  assign bus.req_ready = !w_stall;
  assign w_accept      = bus.req_valid && !w_stall;
  assign w_idx         = bus.req_addr[AU_W-1:OFF_W];
  assign w_off         = bus.req_addr[OFF_W-1:0];

  generate
    if (AU_W < WIDTH) begin : g_range
      assign w_range_err = |bus.req_addr[WIDTH-1:AU_W];
    end else begin : g_no_range
      assign w_range_err = 1'b0;
    end
  endgenerate

  function automatic logic [NB-1:0] lane_mask(input int size, input int pos);
    logic [NB-1:0] m;
    m = '0;
    for (int k = 0; k < NB; k++) begin
      m[k] = (k >= pos) && (k < pos + size);
    end
    return m;
  endfunction

  // Legal enables: a power-of-two run starting at a multiple of its size,
  // and the address byte offset must point at its lowest lane.
  always_comb begin
    w_be_err = 1'b1;
    for (int s = 1; s <= NB; s = s * 2) begin
      for (int p = 0; p < NB; p = p + s) begin
        if (bus.req_byteen == lane_mask(s, p) && w_off == OFF_W'(p)) begin
          w_be_err = 1'b0;
        end
      end
    end
  end

  assign w_err     = w_range_err || w_be_err;
  assign w_rd_word = (!bus.req_write && !w_err) ? r_mem[w_idx] : '0;

  always_ff @(posedge clk) begin
    if (w_accept && bus.req_write && !w_err) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.req_byteen[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 captures the word at acceptance, so later stores never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_data[i] <= '0;
      end
    end else if (!w_stall) begin
      r_vld[0]  <= w_accept;
      r_err[0]  <= w_accept && w_err;
      r_data[0] <= w_accept ? w_rd_word : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_err[i]  <= r_err[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign bus.rsp_valid = r_vld[READ_LATENCY-1];
  assign bus.rsp_err   = r_err[READ_LATENCY-1];
  assign bus.rsp_rdata = r_data[READ_LATENCY-1];

`ifdef DMEM_ACCESS_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_load  <= '0;
      cnt_store <= '0;
      cnt_err   <= '0;
    end else if (w_accept) begin
      if (w_err) begin
        cnt_err <= cnt_err + 32'd1;
      end else if (bus.req_write) begin
        cnt_store <= cnt_store + 32'd1;
      end else begin
        cnt_load <= cnt_load + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_pipelined.sv
// ============================================================================
// Module      : tb_dmem_pipelined
// Description : Scoreboard bench for dmem_pipelined at READ_LATENCY 1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_pipelined;

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          st0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int stalls [2] = '{0, 0};
  exp_t sbq [$];

  logic [1:0]  d_valid, d_write, d_rrdy;
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [3:0]  d_be [2];
  logic [1:0]  m_ready, m_rvalid, m_err;
  logic [31:0] m_rdata [2];

  dmem_pipelined_if #(.WIDTH(32)) bus0 ();
  dmem_pipelined_if #(.WIDTH(32)) bus1 ();

  assign bus0.req_valid  = d_valid[0];
  assign bus0.req_write  = d_write[0];
  assign bus0.req_addr   = d_addr[0];
  assign bus0.req_wdata  = d_wdata[0];
  assign bus0.req_byteen = d_be[0];
  assign bus0.rsp_ready  = d_rrdy[0];
  assign bus1.req_valid  = d_valid[1];
  assign bus1.req_write  = d_write[1];
  assign bus1.req_addr   = d_addr[1];
  assign bus1.req_wdata  = d_wdata[1];
  assign bus1.req_byteen = d_be[1];
  assign bus1.rsp_ready  = d_rrdy[1];
  assign m_ready[0]  = bus0.req_ready;
  assign m_rvalid[0] = bus0.rsp_valid;
  assign m_err[0]    = bus0.rsp_err;
  assign m_rdata[0]  = bus0.rsp_rdata;
  assign m_ready[1]  = bus1.req_ready;
  assign m_rvalid[1] = bus1.rsp_valid;
  assign m_err[1]    = bus1.rsp_err;
  assign m_rdata[1]  = bus1.rsp_rdata;

`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] cl0, cs0, ce0, cl1, cs1, ce1;
`endif

  dmem_pipelined #(.WIDTH(32), .DEPTH_WORDS(1024), .READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
`ifdef DMEM_ACCESS_CNT_EN
    , .cnt_load(cl0), .cnt_store(cs0), .cnt_err(ce0)
`endif
  );

  dmem_pipelined #(.WIDTH(32), .DEPTH_WORDS(1024), .READ_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
`ifdef DMEM_ACCESS_CNT_EN
    , .cnt_load(cl1), .cnt_store(cs1), .cnt_err(ce1)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: samples 2ns after each negedge, well away from the active edge.
  logic [1:0] prev_stall = 2'b00;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          prev_stall[d] = 1'b0;
        end else begin
          if (m_rvalid[d]) begin
            if (sbq.size() == 0 || sbq[0].dut != d) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_rsp dut%0d: got rdata 0x%08h, expected no response", d, m_rdata[d]);
            end else begin
              if (!prev_stall[d]) begin
                check($sformatf("latency_dut%0d", d), 32'(cyc),
                      32'(sbq[0].acc + ((d == 0) ? 1 : 3) - 1 + stalls[d] - sbq[0].st0));
              end
              if (d_rrdy[d]) begin
                e = sbq.pop_front();
                check($sformatf("rdata_dut%0d", d), m_rdata[d], e.rdata);
                check($sformatf("err_dut%0d", d), 32'(m_err[d]), 32'(e.err));
              end
            end
          end
          prev_stall[d] = m_rvalid[d] && !d_rrdy[d];
          if (prev_stall[d]) stalls[d]++;
        end
      end
    end
  end

  task automatic issue(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] er, input logic ee);
    exp_t e;
    int   t;
    @(negedge clk);
    d_valid[d] = 1'b1;
    d_write[d] = wr;
    d_addr[d]  = addr;
    d_wdata[d] = wdata;
    d_be[d]    = be;
    #1;
    t = 0;
    while (!m_ready[d] && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!m_ready[d]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_ready_timeout dut%0d: got req_ready 0, expected 1 within 100 cycles", d);
      d_valid[d] = 1'b0;
      return;
    end
    e.dut = d; e.rdata = er; e.err = ee; e.acc = cyc + 1; e.st0 = stalls[d];
    sbq.push_back(e);
    @(posedge clk);
    #1;
    d_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d outstanding responses, expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  logic [31:0] ld_addr [8] = '{32'h10, 32'h20, 32'h00, 32'h30, 32'h10, 32'h20, 32'h00, 32'h30};
  logic [31:0] ld_exp  [8] = '{32'hDEADBEEF, 32'hAA11CCDD, 32'h01020304, 32'h12345678,
                               32'hDEADBEEF, 32'hAA11CCDD, 32'h01020304, 32'h12345678};

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion within 200us");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    d_valid = '0;
    d_write = '0;
    d_rrdy  = 2'b11;
    for (int i = 0; i < 2; i++) begin
      d_addr[i] = '0; d_wdata[i] = '0; d_be[i] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    check("reset_rsp_valid_l1", 32'(m_rvalid[0]), 32'd0);
    check("reset_rsp_valid_l3", 32'(m_rvalid[1]), 32'd0);
    check("reset_req_ready_l3", 32'(m_ready[1]), 32'd1);
    check("reset_rsp_rdata_l3", m_rdata[1], 32'd0);
    check("reset_rsp_err_l3", 32'(m_err[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic store/load on both latencies
    for (int d = 0; d < 2; d++) begin
      issue(d, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
      issue(d, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
      drain();
    end

    // Byte-lane merge
    issue(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0);
    issue(1, 1'b1, 32'h22, 32'h00110000, 4'h4, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h20, 32'h0, 4'hF, 32'hAA11CCDD, 1'b0);
    // Alignment and range checks
    issue(1, 1'b1, 32'h00, 32'h01020304, 4'hF, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h21, 32'h0, 4'h3, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h22, 32'h0, 4'hC, 32'hAA11CCDD, 1'b0);
    issue(1, 1'b0, 32'h20, 32'h0, 4'h6, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h23, 32'h0, 4'h8, 32'hAA11CCDD, 1'b0);
    issue(1, 1'b1, 32'h1000, 32'h55555555, 4'hF, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h00, 32'h0, 4'hF, 32'h01020304, 1'b0);
    // Load then store to the same word on the next edge
    issue(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h30, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);
    issue(1, 1'b1, 32'h30, 32'h12345678, 4'hF, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h30, 32'h0, 4'hF, 32'h12345678, 1'b0);
    drain();

    // Eight back-to-back loads with a three-cycle consumer stall
    fork
      begin
        for (int i = 0; i < 8; i++) issue(1, 1'b0, ld_addr[i], 32'h0, 4'hF, ld_exp[i], 1'b0);
      end
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          d_rrdy[1] = !(k >= 3 && k <= 5);
          if (k >= 3 && k <= 5) begin
            #1;
            check("stall_req_ready", 32'(m_ready[1]), 32'd0);
          end
        end
        d_rrdy[1] = 1'b1;
      end
    join
    drain();

    // Reset with two loads in flight
    d_rrdy[1] = 1'b0;
    issue(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    issue(1, 1'b0, 32'h20, 32'h0, 4'hF, 32'hAA11CCDD, 1'b0);
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_inflight_rsp_valid", 32'(m_rvalid[1]), 32'd0);
    sbq.delete();
    d_rrdy[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_req_ready", 32'(m_ready[1]), 32'd1);
`ifdef DMEM_ACCESS_CNT_EN
    check("cnt_load_zero", cl1, 32'd0);
    check("cnt_store_zero", cs1, 32'd0);
    check("cnt_err_zero", ce1, 32'd0);
`endif
    repeat (8) @(negedge clk);
    // Memory survives reset
    issue(1, 1'b0, 32'h30, 32'h0, 4'hF, 32'h12345678, 1'b0);
    issue(1, 1'b1, 32'h40, 32'h11111111, 4'hF, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    issue(1, 1'b1, 32'h44, 32'h000000AB, 4'h1, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h1004, 32'h0, 4'hF, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h20, 32'h0, 4'hF, 32'hAA11CCDD, 1'b0);
    drain();
`ifdef DMEM_ACCESS_CNT_EN
    check("cnt_load", cl1, 32'd3);
    check("cnt_store", cs1, 32'd2);
    check("cnt_err", ce1, 32'd1);
    rst_n = 1'b0;
    #1;
    check("cnt_load_reset", cl1, 32'd0);
    check("cnt_store_reset", cs1, 32'd0);
    check("cnt_err_reset", ce1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_pipelined.md
Name: dmem_pipelined

Overview:
- Parametrised data memory for the load/store unit, the successor to the single-cycle combinational-read data memory.
- Valid/ready request channel with byte address, byte enables and alignment/range checking.
- Configurable read latency; one response per request, in order, with error flag.
- Sits between the LSU and the word-array storage, replacing the single-cycle dmem on the dmem bus.

Parameters:
- WIDTH, 32, data and address width in bits; must be 32 or 64.
- DEPTH_WORDS, 1024, number of WIDTH-bit words; must be a power of two.
- READ_LATENCY, 1, cycles from request acceptance to response valid; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset; asynchronous assert, active-low, synchronous deassert expected from the reset tree.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept the request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  WIDTH  byte address.
- req_wdata  input  WIDTH  store data, lane-aligned (byte k on bits 8k+7:8k).
- req_byteen  input  WIDTH/8  byte-lane enables.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  WIDTH  full word read; 0 for stores and errored accesses.
- rsp_err  output  1  access rejected (range or alignment).

Behaviour:
- Handshake:
  - Request accepted on a posedge with req_valid && req_ready.
  - Response transferred on a posedge with rsp_valid && rsp_ready.
  - Responses are in order; stores also produce a response.
- Pipeline:
  - READ_LATENCY stages, each holding valid, rdata and err; rsp_* driven from the last stage.
  - Global stall when rsp_valid && !rsp_ready: all stages hold and req_ready = 0.
  - Otherwise the pipeline advances and req_ready = 1.
  - req_ready is combinational from rsp_valid and rsp_ready only; it has no dependency on req_valid.
  - Throughput: one request per cycle when rsp_ready is held high.
  - Latency: request accepted at edge N gives rsp_valid high after edge N+READ_LATENCY−1 (READ_LATENCY=1: response valid the cycle after acceptance).
- Addressing and error checks:
  - Word index = req_addr[log2(DEPTH_WORDS)+log2(WIDTH/8)−1 : log2(WIDTH/8)]; the low log2(WIDTH/8) bits are the byte offset.
  - err = 1 if any req_addr bit above the index is set (out of range).
  - err = 1 if byteen is not a naturally aligned power-of-two-sized contiguous run: legal for WIDTH=32 is 0001/0010/0100/1000/0011/1100/1111.
  - err = 1 if the byte offset differs from the position of the lowest set byteen bit.
  - err = 1 if byteen = 0.
- Store: when accepted without error, the enabled lanes are written at the acceptance edge; disabled lanes are unchanged. An errored store leaves memory unchanged.
- Load: the word is sampled at the acceptance edge. Later stores do not alter in-flight load data.
  - Consequence: a store accepted before a load in program order is visible to that load.
  - A load accepted at edge N is not affected by a store accepted at edge N+1.
- Reset (rst_n low, asynchronous):
  - All stage valids = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 1 after reset.
  - Memory array is not reset.
  - Reset mid-operation drops in-flight responses. Stores already accepted remain committed.

Optional Feature:
- Macro: DMEM_ACCESS_CNT_EN.
- Defined: three extra outputs: cnt_load (32 bits), cnt_store (32 bits), cnt_err (32 bits).
  - cnt_load / cnt_store count accepted error-free loads/stores; cnt_err counts accepted errored requests.
  - All increment at acceptance, wrap modulo 2^32, and reset to 0 on rst_n.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Store addr 0x10, wdata 0xDEADBEEF, byteen 1111; load 0x10 -> rsp_rdata 0xDEADBEEF, err 0; each response READ_LATENCY cycles after acceptance (test READ_LATENCY 1 and 3).
- Store 0xAABBCCDD to 0x20; store byte addr 0x22, wdata 0x00110000, byteen 0100; load 0x20 -> 0xAA11CCDD.
- Load 0x21 with byteen 0011 -> err 1, rdata 0. Store to 0x1000 with DEPTH_WORDS=1024 -> err 1; load 0x0 afterwards shows memory unchanged.
- Back-to-back 8 loads with rsp_ready low for cycles 3–5 -> req_ready low during the stall; responses arrive in order with no drops or duplicates.
- Load 0x30 accepted at edge N and store 0x30 = 0x12345678 at N+1 -> load returns the old value; a following load returns 0x12345678.
- Assert rst_n low with 2 loads in flight -> rsp_valid 0 immediately; after release req_ready=1 and no stale responses. With DMEM_ACCESS_CNT_EN: 3 loads, 2 stores, 1 error -> cnt_load=3, cnt_store=2, cnt_err=1; all 0 after reset.
